// File: rtl/hex_display_pkg.sv
// Shared types and constants for the two-digit hex display arbiter.
package hex_display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int DEFAULT_DWELL = 12_000_000;
    localparam int DEFAULT_GAP   = 1_200_000;

    // Segment pattern that keeps every segment of the active-low display dark.
    localparam logic [6:0] BLANK_SEG = 7'b1111111;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hex_display_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from last_served+1 upward and wraps.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_served,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // First requester found after the last served one wins.
    always_comb begin
        int cand;
        valid = 1'b0;
        idx   = {IDX_W{1'b0}};
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(last_served) + 1 + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end else begin
                cand = cand;
            end
            if (!valid && req[IDX_W'(cand)]) begin
                valid = 1'b1;
                idx   = IDX_W'(cand);
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/hex_display_arbiter.sv
// Shares one two-digit hex display between NUM_REQ requesters: each winner is
// shown for DWELL_CYCLES, followed by GAP_CYCLES of blank display.
module hex_display_arbiter
    import hex_display_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = DEFAULT_DWELL,
    parameter int GAP_CYCLES   = DEFAULT_GAP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [7:0]             hex_val,
    output logic                   blank,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(max_int(DWELL_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   last_q;
    logic [7:0]         hex_val_q;
    logic               blank_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;

    logic               arb_valid;
    logic [IDX_W-1:0]   arb_idx;
    logic [7:0]         sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req         (req),
        .last_served (last_q),
        .valid       (arb_valid),
        .idx         (arb_idx)
    );

    // Byte lane of the current arbitration winner.
    always_comb begin
        sel_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_data = req_data[8*i +: 8];
            end else begin
                sel_data = sel_data;
            end
        end
    end

    // Display ownership FSM; the counter runs from its load value down to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            last_q    <= IDX_W'(NUM_REQ - 1);
            hex_val_q <= 8'h00;
            blank_q   <= 1'b1;
            grant_q   <= {NUM_REQ{1'b0}};
            done_q    <= {NUM_REQ{1'b0}};
        end else begin
            done_q <= {NUM_REQ{1'b0}};
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        state_q   <= SHOW;
                        grant_q   <= NUM_REQ'(1) << arb_idx;
                        hex_val_q <= sel_data;
                        blank_q   <= 1'b0;
                        cnt_q     <= DWELL_LD;
                        last_q    <= arb_idx;
                    end else begin
                        state_q <= IDLE;
                        grant_q <= {NUM_REQ{1'b0}};
                        blank_q <= 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt_q == CNT_ONE) begin
                        done_q  <= grant_q;
                        grant_q <= {NUM_REQ{1'b0}};
                        blank_q <= 1'b1;
                        if (GAP_CYCLES == 0) begin
                            state_q <= IDLE;
                            cnt_q   <= {CNT_W{1'b0}};
                        end else begin
                            state_q <= GAP;
                            cnt_q   <= GAP_LD;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                GAP: begin
                    if (cnt_q == CNT_ONE) begin
                        state_q <= IDLE;
                        cnt_q   <= {CNT_W{1'b0}};
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= {CNT_W{1'b0}};
                    grant_q <= {NUM_REQ{1'b0}};
                    blank_q <= 1'b1;
                end
            endcase
        end
    end

    assign hex_val = hex_val_q;
    assign blank   = blank_q;
    assign grant   = grant_q;
    assign done    = done_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Self-checking bench: a GAP=2 and a GAP=0 instance driven by shared directed stimulus.
module tb_hex_display_arbiter;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;

    logic [7:0] hex_a, hex_b;
    logic       blank_a, blank_b;
    logic [3:0] grant_a, grant_b, done_a, done_b;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    int         m_age[2];
    int         m_owner[2];
    int         m_last[2];
    logic [7:0] m_hex[2];

    hex_display_arbiter #(.NUM_REQ(4), .DWELL_CYCLES(4), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .hex_val(hex_a), .blank(blank_a), .grant(grant_a), .done(done_a)
    );

    hex_display_arbiter #(.NUM_REQ(4), .DWELL_CYCLES(4), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .hex_val(hex_b), .blank(blank_b), .grant(grant_b), .done(done_b)
    );

    always #5 clk = ~clk;

    function automatic int gap_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    // Model: age = cycles since the grant edge; the display is free once age exceeds D+gap.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_age[i] = -1; m_last[i] = 3; m_hex[i] = 8'h00; m_owner[i] = 0;
            end else if (m_age[i] < 0 || m_age[i] > D + gap_of(i)) begin
                m_age[i] = -1;
                for (int k = 1; k <= 4; k++) begin
                    int c;
                    c = (m_last[i] + k) % 4;
                    if (m_age[i] < 0 && req[2'(c)]) begin
                        m_age[i] = 1; m_owner[i] = c; m_last[i] = c;
                        m_hex[i] = 8'(req_data >> (8 * c));
                    end
                end
            end else begin
                m_age[i]++;
            end
        end
    end

    // Compare both instances against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [3:0] eg, ed;
                logic [7:0] h; logic b; logic [3:0] g, d;
                bit showing;
                showing = (m_age[i] >= 1 && m_age[i] <= D);
                eg = showing ? 4'(1 << m_owner[i]) : 4'b0000;
                ed = (m_age[i] == D + 1) ? 4'(1 << m_owner[i]) : 4'b0000;
                h = (i == 0) ? hex_a : hex_b;
                b = (i == 0) ? blank_a : blank_b;
                g = (i == 0) ? grant_a : grant_b;
                d = (i == 0) ? done_a : done_b;
                check($sformatf("model_hex%0d", i), {24'h0, h}, {24'h0, m_hex[i]});
                check($sformatf("model_blank%0d", i), {31'h0, b}, {31'h0, !showing});
                check($sformatf("model_grant%0d", i), {28'h0, g}, {28'h0, eg});
                check($sformatf("model_done%0d", i), {28'h0, d}, {28'h0, ed});
                check($sformatf("onehot%0d", i), {31'h0, ($countones(g) <= 1 && $countones(d) <= 1)}, 32'd1);
            end
        end
    end

    initial begin
        rst = 1'b1; req = 4'b0000; req_data = 32'h0;
        tick();
        chk_en = 1'b1;
        check("rst_hex", {24'h0, hex_a}, 32'h00);
        check("rst_blank", {31'h0, blank_a}, 32'd1);
        check("rst_grant", {28'h0, grant_a}, 32'h0);
        check("rst_done", {28'h0, done_a}, 32'h0);

        // Single requester 2.
        rst = 1'b0;
        tick(); req = 4'b0100; req_data[23:16] = 8'h3C;
        tick();
        check("single_grant_c2", {28'h0, grant_a}, 32'h4);
        check("single_hex_c2", {24'h0, hex_a}, 32'h3C);
        check("single_blank_c2", {31'h0, blank_a}, 32'd0);
        repeat (3) tick();
        check("single_grant_c5", {28'h0, grant_a}, 32'h4);
        tick(); req = 4'b0000;
        check("single_done_c6", {28'h0, done_a}, 32'h4);
        check("single_grant_c6", {28'h0, grant_a}, 32'h0);
        check("single_blank_c6", {31'h0, blank_a}, 32'd1);
        tick();
        check("single_done_c7", {28'h0, done_a}, 32'h0);
        check("single_blank_c7", {31'h0, blank_a}, 32'd1);
        tick();
        check("single_idle_c8", {28'h0, grant_a}, 32'h0);

        // All requesters: order 0,1,2,3,0 every 7 cycles.
        do_reset();
        tick(); req = 4'b1111; req_data = 32'h44332211;
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_grant%0d", k), {28'h0, grant_a}, 32'(1 << (k % 4)));
            check($sformatf("rr_hex%0d", k), {24'h0, hex_a}, 32'(8'h11 * ((k % 4) + 1)));
            repeat (7) tick();
        end

        // Mid-SHOW request drop and data change.
        do_reset();
        tick(); req = 4'b0010; req_data = 32'h00001100;
        tick();
        tick(); req = 4'b0000; req_data = 32'h00009900;
        check("midshow_hex_c3", {24'h0, hex_a}, 32'h11);
        repeat (2) tick();
        check("midshow_hex_c5", {24'h0, hex_a}, 32'h11);
        check("midshow_grant_c5", {28'h0, grant_a}, 32'h2);
        tick();
        check("midshow_done_c6", {28'h0, done_a}, 32'h2);
        repeat (3) tick();
        check("midshow_no_regrant", {28'h0, grant_a}, 32'h0);

        // Reset during SHOW.
        do_reset();
        tick(); req = 4'b1111; req_data = 32'h44332211;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("rstshow_grant", {28'h0, grant_a}, 32'h0);
        check("rstshow_blank", {31'h0, blank_a}, 32'd1);
        check("rstshow_hex", {24'h0, hex_a}, 32'h00);
        check("rstshow_done", {28'h0, done_a}, 32'h0);
        rst = 1'b0;
        tick();
        check("rstshow_regrant", {28'h0, grant_a}, 32'h1);
        check("rstshow_rehex", {24'h0, hex_a}, 32'h11);

        // GAP_CYCLES=0 instance with requester 0 held.
        do_reset();
        tick(); req = 4'b0001; req_data = 32'h0000005A;
        tick();
        check("nogap_grant_c2", {28'h0, grant_b}, 32'h1);
        check("nogap_hex_c2", {24'h0, hex_b}, 32'h5A);
        repeat (3) tick();
        check("nogap_grant_c5", {28'h0, grant_b}, 32'h1);
        tick(); req_data = 32'h000000A5;
        check("nogap_done_c6", {28'h0, done_b}, 32'h1);
        check("nogap_grant_c6", {28'h0, grant_b}, 32'h0);
        check("nogap_blank_c6", {31'h0, blank_b}, 32'd1);
        check("gap_done_c6", {28'h0, done_a}, 32'h1);
        tick();
        check("nogap_regrant_c7", {28'h0, grant_b}, 32'h1);
        check("nogap_rehex_c7", {24'h0, hex_b}, 32'hA5);
        check("nogap_blank_c7", {31'h0, blank_b}, 32'd0);
        req = 4'b0000;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_display_arbiter.md
HEX_DISPLAY_ARBITER -- requirements
Module: hex_display_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the two-digit hex display; legal range 2..8.
REQ-002 Parameter DWELL_CYCLES, default 12_000_000: cycles a granted value is shown; must be at least 1.
REQ-003 Parameter GAP_CYCLES, default 1_200_000: blank cycles between consecutive values; 0 is legal.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  system clock (12 MHz on board).
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req  input  NUM_REQ  per-requester request; held high until done.
REQ-008 req_data  input  8*NUM_REQ  requester i value at bits [8i+7:8i]; stable while req[i] is high.
REQ-009 hex_val  output  8  value driven to the display driver's hex_val input.
REQ-010 blank  output  1  high when the display must be dark; the top level gates the segment pins with it.
REQ-011 grant  output  NUM_REQ  one-hot owner of the display; all zero when no owner.
REQ-012 done  output  NUM_REQ  one-cycle pulse to requester i when its dwell completes.

Function
REQ-013 The FSM SHALL have states IDLE, SHOW and GAP, with all outputs registered.
REQ-014 IDLE with any req bit high: the next cycle SHALL enter SHOW, set grant to the winner, latch the winner's req_data into hex_val, clear blank and load the dwell counter.
REQ-015 Winner selection SHALL be round-robin: search starts at (last_served+1) mod NUM_REQ and wraps.
REQ-016 The last_served pointer SHALL update on every grant.
REQ-017 IDLE with no req bit high: the FSM SHALL stay in IDLE with blank=1 and grant=0.
REQ-018 SHOW SHALL last exactly DWELL_CYCLES cycles, with grant and hex_val constant throughout.
REQ-019 Changes on req_data during SHOW SHALL be ignored.
REQ-020 Deassertion of req during SHOW SHALL NOT shorten the dwell; done still pulses at its end.
REQ-021 In the cycle after the last SHOW cycle:
- done[owner] SHALL be 1 for exactly one cycle;
- grant SHALL be 0;
- blank SHALL be 1;
- the FSM SHALL enter GAP, or IDLE when GAP_CYCLES=0.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles with blank=1 and hex_val held, then enter IDLE.
REQ-023 Under continuous requests the per-value period SHALL therefore be DWELL_CYCLES+GAP_CYCLES+1 cycles.
REQ-024 A requester that keeps req high after done SHALL be treated as a new request, subject to round-robin.
REQ-025 The counter width SHALL be $clog2(max(DWELL_CYCLES,GAP_CYCLES)+1).
REQ-026 The counter SHALL count down to 1 and never wrap.
REQ-027 At most one grant bit and at most one done bit SHALL be high in any cycle.

Reset
REQ-028 While rst is high at a clock edge, the block SHALL go to: state IDLE, hex_val=8'h00, blank=1, grant=0, done=0, counter=0, last_served=NUM_REQ-1 (so requester 0 has first priority).
REQ-029 Reset during SHOW or GAP SHALL abort the operation immediately with no done pulse.
REQ-030 Arbitration SHALL resume the first cycle after rst falls.

Structure
REQ-031 Package hex_display_pkg SHALL hold:
- the state enum (IDLE, SHOW, GAP);
- default DWELL and GAP constants;
- the blank segment pattern 7'b1111111.
REQ-032 Round-robin selection SHALL be a combinational sub-module, rr_arbiter, taking (req, last_served) and producing (valid, idx).
REQ-033 The display driver SHALL NOT be instantiated inside this block.

Verification
All scenarios use NUM_REQ=4, DWELL_CYCLES=4, GAP_CYCLES=2, with reset released at cycle 0.
REQ-034 Single requester: req=4'b0100, data2=8'h3C at cycle 1 -> cycles 2-5 grant=0100, hex_val=3C, blank=0; cycle 6 done=0100; cycles 6-7 blank=1; cycle 8 IDLE.
REQ-035 All requesters: req=4'b1111 held -> grants in order 0,1,2,3,0, each starting 7 cycles after the previous one.
REQ-036 Mid-SHOW changes: req[1] dropped and data1 changed 0x11->0x99 in the second SHOW cycle -> hex_val stays 0x11 for all 4 cycles and done[1] still pulses.
REQ-037 Reset during SHOW: rst in the third SHOW cycle -> next cycle grant=0, blank=1, hex_val=00, no done; with req=4'b1111 held, requester 0 is granted after release.
REQ-038 No gap: GAP_CYCLES=0 with req=4'b0001 held -> SHOW 4 cycles, 1 IDLE cycle (done=0001), SHOW again, with hex_val reloaded.
